// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the instruction-fetch and data ports.
// Data accesses win by default; a starve counter forces a fetch after STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int ADDR_BITS    = 16,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [ADDR_BITS-1:0] InstrAddr,
    input  logic                 InstrRead,
    output logic [WORD_SIZE-1:0] InstrIn,
    output logic                 InstrWaitreq,
    input  logic [ADDR_BITS-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    output logic [ADDR_BITS-1:0] MemAddr,
    output logic [WORD_SIZE-1:0] MemWrData,
    output logic                 MemRead,
    output logic                 MemWrite,
    input  logic                 MemWaitreq,
    input  logic [WORD_SIZE-1:0] MemRdData
);
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
    typedef enum logic {OWN_DATA = 1'b0, OWN_INSTR = 1'b1} owner_e;

    state_e               state_q, state_d;
    owner_e               owner_q, owner_d;
    logic                 is_wr_q, is_wr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [STV_W-1:0]     starve_q, starve_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;

    logic data_req;
    logic issue;
    logic done_instr;
    logic done_data;

    assign data_req = ReadData | WriteData;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        is_wr_d  = is_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lat_d    = lat_q;
        starve_d = starve_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                // Data cannot overflow the counter: with InstrRead high it only wins below the limit.
                if (data_req && ((starve_q < STV_W'(STARVE_LIMIT)) || !InstrRead)) begin
                    owner_d = OWN_DATA;
                    is_wr_d = WriteData;
                    addr_d  = DataAddr;
                    wdata_d = DataOut;
                    state_d = S_ISSUE;
                    if (InstrRead) starve_d = starve_q + STV_W'(1);
                end else if (InstrRead) begin
                    owner_d  = OWN_INSTR;
                    is_wr_d  = 1'b0;
                    addr_d   = InstrAddr;
                    state_d  = S_ISSUE;
                    starve_d = '0;
                end
            end
            S_ISSUE: begin
                if (!MemWaitreq) begin
                    if (is_wr_q) begin
                        state_d = S_DONE;
                    end else begin
                        lat_d   = LAT_W'(READ_LATENCY);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_d == '0) begin
                    rdata_d = MemRdData;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_DATA;
            is_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lat_q    <= '0;
            starve_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            is_wr_q  <= is_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            rdata_q  <= rdata_d;
        end
    end

    // Memory bus is idle (all zero) whenever no command is being presented.
    assign issue     = (state_q == S_ISSUE);
    assign MemRead   = issue & ~is_wr_q;
    assign MemWrite  = issue & is_wr_q;
    assign MemAddr   = issue ? addr_q : '0;
    assign MemWrData = issue ? wdata_q : '0;

    assign done_instr   = (state_q == S_DONE) && (owner_q == OWN_INSTR);
    assign done_data    = (state_q == S_DONE) && (owner_q == OWN_DATA);
    assign InstrWaitreq = InstrRead & ~done_instr;
    assign DataWaitreq  = data_req & ~done_data;
    assign InstrIn      = done_instr ? rdata_q : '0;
    assign DataIn       = done_data ? rdata_q : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: single-port transaction table with a scoreboard,
// plus hand sequences for contention, starvation, backpressure and reset mid-access.
module tb_mem_port_arbiter;
    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_BOTH  = 3;
    localparam int NVEC    = 10;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [15:0] InstrAddr = '0;
    logic        InstrRead = 1'b0;
    logic [15:0] InstrIn;
    logic        InstrWaitreq;
    logic [15:0] DataAddr = '0;
    logic [15:0] DataOut = '0;
    logic        ReadData = 1'b0;
    logic        WriteData = 1'b0;
    logic [15:0] DataIn;
    logic        DataWaitreq;
    logic [15:0] MemAddr;
    logic [15:0] MemWrData;
    logic        MemRead;
    logic        MemWrite;
    logic        MemWaitreq = 1'b0;
    logic [15:0] MemRdData;

    logic [15:0] mem [256];

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    typedef struct {
        int          kind;
        logic [15:0] data;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_port_arbiter dut (
        .Clock(Clock), .Resetn(Resetn),
        .InstrAddr(InstrAddr), .InstrRead(InstrRead), .InstrIn(InstrIn), .InstrWaitreq(InstrWaitreq),
        .DataAddr(DataAddr), .DataOut(DataOut), .ReadData(ReadData), .WriteData(WriteData),
        .DataIn(DataIn), .DataWaitreq(DataWaitreq),
        .MemAddr(MemAddr), .MemWrData(MemWrData), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemWaitreq(MemWaitreq), .MemRdData(MemRdData)
    );

    always #5 Clock = ~Clock;

    // Memory with one cycle of read latency after accept.
    always @(posedge Clock) begin
        if (MemRead && !MemWaitreq) MemRdData <= mem[MemAddr[7:0]];
        if (MemWrite && !MemWaitreq) mem[MemAddr[7:0]] <= MemWrData;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        exp_t e;
        int   cyc, rdc, wrc;
        bit   done;
        @(posedge Clock); #1;
        case (v.kind)
            K_FETCH: begin InstrAddr = v.addr; InstrRead = 1'b1; end
            K_LOAD:  begin DataAddr = v.addr; ReadData = 1'b1; end
            K_STORE: begin DataAddr = v.addr; DataOut = v.wdata; WriteData = 1'b1; end
            default: begin DataAddr = v.addr; DataOut = v.wdata; WriteData = 1'b1; ReadData = 1'b1; end
        endcase
        sb.push_back('{v.kind, v.exp_data, v.exp_lat, v.exp_rd, v.exp_wr});
        cyc = 1; rdc = 0; wrc = 0; done = 1'b0;
        while (!done && cyc <= 40) begin
            @(negedge Clock);
            if (MemRead)  rdc++;
            if (MemWrite) wrc++;
            if ((v.kind == K_FETCH) ? !InstrWaitreq : !DataWaitreq) done = 1'b1;
            else begin
                @(posedge Clock);
                cyc++;
            end
        end
        e = sb.pop_front();
        chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_lat", idx), 32'(cyc), 32'(e.lat));
        chk($sformatf("v%0d_rdcyc", idx), 32'(rdc), 32'(e.rd));
        chk($sformatf("v%0d_wrcyc", idx), 32'(wrc), 32'(e.wr));
        if (e.kind == K_FETCH) chk($sformatf("v%0d_instrin", idx), 32'(InstrIn), 32'(e.data));
        if (e.kind == K_LOAD)  chk($sformatf("v%0d_datain", idx), 32'(DataIn), 32'(e.data));
        @(posedge Clock); #1;
        InstrRead = 1'b0; ReadData = 1'b0; WriteData = 1'b0;
    endtask

    initial begin
        bit gexp [6];
        int n, cyc, rdc;
        bit done;

        vecs[0] = '{K_STORE, 16'h0040, 16'h0F0F, 16'h0000, 3, 0, 1};
        vecs[1] = '{K_LOAD,  16'h0040, 16'h0000, 16'h0F0F, 4, 1, 0};
        vecs[2] = '{K_STORE, 16'h0010, 16'hBEEF, 16'h0000, 3, 0, 1};
        vecs[3] = '{K_FETCH, 16'h0010, 16'h0000, 16'hBEEF, 4, 1, 0};
        vecs[4] = '{K_STORE, 16'h00FF, 16'hFFFF, 16'h0000, 3, 0, 1};
        vecs[5] = '{K_FETCH, 16'h00FF, 16'h0000, 16'hFFFF, 4, 1, 0};
        vecs[6] = '{K_BOTH,  16'h0020, 16'h5A5A, 16'h0000, 3, 0, 1};
        vecs[7] = '{K_LOAD,  16'h0020, 16'h0000, 16'h5A5A, 4, 1, 0};
        vecs[8] = '{K_FETCH, 16'h0040, 16'h0000, 16'h0F0F, 4, 1, 0};
        vecs[9] = '{K_LOAD,  16'h0010, 16'h0000, 16'hBEEF, 4, 1, 0};

        // T1: reset held with both ports requesting
        InstrRead = 1'b1; ReadData = 1'b1; InstrAddr = 16'h0010; DataAddr = 16'h0040;
        #12;
        chk("t1_memread", 32'(MemRead), 32'd0);
        chk("t1_memwrite", 32'(MemWrite), 32'd0);
        chk("t1_memaddr", 32'(MemAddr), 32'd0);
        chk("t1_instr_wait", 32'(InstrWaitreq), 32'd1);
        chk("t1_data_wait", 32'(DataWaitreq), 32'd1);
        chk("t1_instrin", 32'(InstrIn), 32'd0);
        chk("t1_datain", 32'(DataIn), 32'd0);
        #1; InstrRead = 1'b0; ReadData = 1'b0;
        #4; Resetn = 1'b1;

        for (int i = 0; i < NVEC; i++) run_txn(i, vecs[i]);

        // T3: store and fetch raised together; store goes first
        @(posedge Clock); #1;
        DataAddr = 16'h0040; DataOut = 16'h1234; WriteData = 1'b1;
        InstrAddr = 16'h0010; InstrRead = 1'b1;
        @(negedge Clock);
        chk("t3_c1_memwrite", 32'(MemWrite), 32'd0);
        @(negedge Clock);
        chk("t3_c2_memwrite", 32'(MemWrite), 32'd1);
        chk("t3_c2_memread", 32'(MemRead), 32'd0);
        chk("t3_c2_addr", 32'(MemAddr), 32'h0040);
        chk("t3_c2_wdata", 32'(MemWrData), 32'h1234);
        @(negedge Clock);
        chk("t3_c3_data_wait", 32'(DataWaitreq), 32'd0);
        chk("t3_c3_instr_wait", 32'(InstrWaitreq), 32'd1);
        @(posedge Clock); #1; WriteData = 1'b0;
        @(negedge Clock);
        chk("t3_c4_memread", 32'(MemRead), 32'd0);
        @(negedge Clock);
        chk("t3_c5_memread", 32'(MemRead), 32'd1);
        chk("t3_c5_addr", 32'(MemAddr), 32'h0010);
        @(negedge Clock);
        chk("t3_c6_instr_wait", 32'(InstrWaitreq), 32'd1);
        @(negedge Clock);
        chk("t3_c7_instr_wait", 32'(InstrWaitreq), 32'd0);
        chk("t3_c7_instrin", 32'(InstrIn), 32'hBEEF);
        @(posedge Clock); #1; InstrRead = 1'b0;

        // T4: continuous loads with a pending fetch; 5th grant must go to fetch
        gexp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        @(posedge Clock); #1;
        InstrAddr = 16'h0010; InstrRead = 1'b1; DataAddr = 16'h0040; ReadData = 1'b1;
        n = 0; cyc = 0;
        while (n < 6 && cyc < 80) begin
            @(negedge Clock);
            cyc++;
            if (MemRead) begin
                chk($sformatf("t4_grant%0d_is_instr", n), 32'(MemAddr == 16'h0010), 32'(gexp[n]));
                n++;
            end
        end
        chk("t4_grants", 32'(n), 32'd6);
        @(posedge Clock); #1; InstrRead = 1'b0; ReadData = 1'b0;
        repeat (8) @(posedge Clock);

        // T5: memory stalls the command for three cycles
        #1; MemWaitreq = 1'b1; DataAddr = 16'h0040; ReadData = 1'b1;
        cyc = 1; rdc = 0; done = 1'b0;
        while (!done && cyc <= 30) begin
            @(negedge Clock);
            if (MemRead) begin
                rdc++;
                chk($sformatf("t5_addr%0d", rdc), 32'(MemAddr), 32'h0040);
                if (rdc == 4) MemWaitreq = 1'b0;
            end
            if (!DataWaitreq) done = 1'b1;
            else begin
                @(posedge Clock);
                cyc++;
            end
        end
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_rdcyc", 32'(rdc), 32'd4);
        chk("t5_lat", 32'(cyc), 32'd7);
        chk("t5_datain", 32'(DataIn), 32'h1234);
        @(posedge Clock); #1; ReadData = 1'b0; MemWaitreq = 1'b0;

        // T6: reset pulse while waiting for read data; the held fetch then reissues
        @(posedge Clock); #1; InstrAddr = 16'h0040; InstrRead = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        chk("t6_c2_memread", 32'(MemRead), 32'd1);
        @(negedge Clock);
        Resetn = 1'b0;
        #1;
        chk("t6_rst_memread", 32'(MemRead), 32'd0);
        chk("t6_rst_instr_wait", 32'(InstrWaitreq), 32'd1);
        chk("t6_rst_instrin", 32'(InstrIn), 32'd0);
        #1; Resetn = 1'b1;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 20) begin
            @(posedge Clock);
            cyc++;
            @(negedge Clock);
            if (!InstrWaitreq) done = 1'b1;
        end
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_cycles_after_reset", 32'(cyc), 32'd3);
        chk("t6_instrin", 32'(InstrIn), 32'h1234);
        @(posedge Clock); #1; InstrRead = 1'b0;
        repeat (3) @(posedge Clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
